// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I control unit: main FSM, ALU decoder, immediate select
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Moore control word for a given state; decoded from the next state so it lands registered.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_d = decode_state(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Enables are gated by rst_n so reset suppresses every pulse while selects hold FETCH values.
    assign PCWrite   = rst_n & (ctrl_q.pc_update | (ctrl_q.branch & zero));
    assign IRWrite   = rst_n & ctrl_q.ir_write;
    assign MemWrite  = rst_n & ctrl_q.mem_write;
    assign RegWrite  = rst_n & ctrl_q.reg_write;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ResultSrc = ctrl_q.result_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign state     = state_q;

    always_comb begin
        ALUControl = 3'b000;
        case (ctrl_q.alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .state     (state)
    );

    // record layout: {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite}
    typedef struct {
        string       name;
        logic [19:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [19:0] expect_rec(input logic [3:0] s, input logic [2:0] alu_exec,
                                               input logic [1:0] imm, input logic z);
        logic       pc, adr, mw, ir, rw;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0; rs = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (s)
            4'd0:  begin ir = 1; pc = 1; rs = 2'b10; b = 2'b10; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  begin adr = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin a = 2'b10; alu = alu_exec; end
            4'd7:  begin a = 2'b10; b = 2'b01; alu = alu_exec; end
            4'd8:  begin rw = 1; end
            4'd9:  begin a = 2'b10; alu = alu_exec; pc = z; end
            4'd10: begin a = 2'b01; b = 2'b10; pc = 1; end
            default: ;
        endcase
        return {s, pc, adr, mw, ir, rs, a, b, alu, imm, rw};
    endfunction

    function automatic logic [19:0] reset_rec(input logic [1:0] imm);
        return {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [19:0] act;
            e   = exp_q.pop_front();
            act = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s actual=%05h required=%05h (t=%0t)", e.name, act, e.v, $time);
            end
        end
    end

    // seq holds the expected state sequence, one nibble per cycle, lowest nibble first
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [2:0] alu_exec,
                             input logic [1:0] imm, input int n, input logic [19:0] seq);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.name = $sformatf("%s_c%0d", name, i);
            e.v    = expect_rec(seq[4*i +: 4], alu_exec, imm, z);
            exp_q.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_reset(input string name, input logic [1:0] imm);
        exp_t e;
        e.name = name;
        e.v    = reset_rec(imm);
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) push_reset($sformatf("reset_hold%0d", i), 2'b00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 5, 20'h43210);
        run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 4, 20'h05210);
        run_instr("r_sub",    7'b0110011, 3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 4, 20'h08610);
        run_instr("r_add_z1", 7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000, 2'b00, 4, 20'h08610);
        run_instr("r_slt",    7'b0110011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00, 4, 20'h08610);
        run_instr("r_or",     7'b0110011, 3'b110, 1'b0, 1'b0, 3'b011, 2'b00, 4, 20'h08610);
        run_instr("r_and",    7'b0110011, 3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 4, 20'h08610);
        run_instr("r_sll",    7'b0110011, 3'b001, 1'b1, 1'b0, 3'b000, 2'b00, 4, 20'h08610);
        run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 4, 20'h08710);
        run_instr("slti",     7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101, 2'b00, 4, 20'h08710);
        run_instr("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 3'b001, 2'b10, 3, 20'h00910);
        run_instr("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 3'b001, 2'b10, 3, 20'h00910);
        run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 3'b000, 2'b11, 4, 20'h08A10);

        // abort a load in MEMREAD: reset lands between edges, so the next sample proves it is asynchronous
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 3, 20'h00210);
        push_reset("abort_async", 2'b00);
        push_reset("abort_hold", 2'b00);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_instr("unsup",    7'b1110011, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2, 20'h00010);
        run_instr("lw_again", 7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 5, 20'h43210);

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0 pending", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
